// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the byte/half/word access controller: size codes, FSM states,
// and the alignment check used to reject requests before any RAM access.
package mem_ctrl_pkg;

   localparam logic [1:0] SIZE_B = 2'b00;
   localparam logic [1:0] SIZE_H = 2'b01;
   localparam logic [1:0] SIZE_W = 2'b10;
   localparam logic [1:0] SIZE_X = 2'b11;

   typedef enum logic [2:0] {
      IDLE,
      RD,
      WAIT,
      WR,
      RESP
   } state_e;

   // Size 11 is always rejected; halves need even, words need 4-byte-aligned addresses.
   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lsb);
      logic bad;
      case (size)
         SIZE_B:  bad = 1'b0;
         SIZE_H:  bad = lsb[0];
         SIZE_W:  bad = (lsb != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane logic: extracts and extends a load lane from a RAM word, and merges
// right-aligned store data into the addressed lane(s) of a RAM word.
module mem_lane_align
   import mem_ctrl_pkg::*;
(
   input  logic [1:0]  size_i,
   input  logic [1:0]  lsb_i,
   input  logic        signed_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rdata_i,
   output logic [31:0] load_o,
   output logic [31:0] merged_o
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   always_comb begin
      byte_lane = rdata_i[7:0];
      case (lsb_i)
         2'd0:    byte_lane = rdata_i[7:0];
         2'd1:    byte_lane = rdata_i[15:8];
         2'd2:    byte_lane = rdata_i[23:16];
         default: byte_lane = rdata_i[31:24];
      endcase
      half_lane = lsb_i[1] ? rdata_i[31:16] : rdata_i[15:0];
   end

   always_comb begin
      load_o = 32'h0;
      case (size_i)
         SIZE_B:  load_o = signed_i ? {{24{byte_lane[7]}}, byte_lane} : {24'h0, byte_lane};
         SIZE_H:  load_o = signed_i ? {{16{half_lane[15]}}, half_lane} : {16'h0, half_lane};
         SIZE_W:  load_o = rdata_i;
         default: load_o = 32'h0;
      endcase
   end

   always_comb begin
      merged_o = rdata_i;
      case (size_i)
         SIZE_B: begin
            case (lsb_i)
               2'd0:    merged_o = {rdata_i[31:8], wdata_i[7:0]};
               2'd1:    merged_o = {rdata_i[31:16], wdata_i[7:0], rdata_i[7:0]};
               2'd2:    merged_o = {rdata_i[31:24], wdata_i[7:0], rdata_i[15:0]};
               default: merged_o = {wdata_i[7:0], rdata_i[23:0]};
            endcase
         end
         SIZE_H:  merged_o = lsb_i[1] ? {wdata_i[15:0], rdata_i[15:0]} : {rdata_i[31:16], wdata_i[15:0]};
         SIZE_W:  merged_o = wdata_i;
         default: merged_o = rdata_i;
      endcase
   end

endmodule

// File: rtl/mem_byte_ctrl.sv
// Sized, byte-addressed access controller in front of a 64x32 single-port block RAM.
// Build option MEM_WORD_FASTPATH_EN: aligned word stores write directly, skipping the RAM read.
module mem_byte_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
) (
   input  logic              Clk,
   input  logic              Rst_n,
   input  logic              Req_Valid,
   output logic              Req_Ready,
   input  logic              Req_Write,
   input  logic [1:0]        Req_Size,
   input  logic              Req_Signed,
   input  logic [ADDR_W-1:0] Req_Addr,
   input  logic [DATA_W-1:0] Req_WData,
   output logic              Rsp_Valid,
   output logic [DATA_W-1:0] Rsp_RData,
   output logic              Rsp_Err,
   output logic              Ram_We,
   output logic [ADDR_W-3:0] Ram_Addr,
   output logic [DATA_W-1:0] Ram_WData,
   input  logic [DATA_W-1:0] Ram_RData
);

   state_e            state_q, state_d;
   logic              write_q, write_d;
   logic [1:0]        size_q, size_d;
   logic              signed_q, signed_d;
   logic [1:0]        lsb_q, lsb_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              ram_we_q, ram_we_d;
   logic [ADDR_W-3:0] ram_addr_q, ram_addr_d;
   logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              rsp_err_q, rsp_err_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic [31:0]       load_data, merged_data;

   mem_lane_align u_align (
      .size_i   (size_q),
      .lsb_i    (lsb_q),
      .signed_i (signed_q),
      .wdata_i  (wdata_q),
      .rdata_i  (Ram_RData),
      .load_o   (load_data),
      .merged_o (merged_data)
   );

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q     <= IDLE;
         write_q     <= 1'b0;
         size_q      <= SIZE_B;
         signed_q    <= 1'b0;
         lsb_q       <= 2'b00;
         wdata_q     <= '0;
         ram_we_q    <= 1'b0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         write_q     <= write_d;
         size_q      <= size_d;
         signed_q    <= signed_d;
         lsb_q       <= lsb_d;
         wdata_q     <= wdata_d;
         ram_we_q    <= ram_we_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   // Every output is registered; each state sets up what the next state must present.
   always_comb begin
      state_d     = state_q;
      write_d     = write_q;
      size_d      = size_q;
      signed_d    = signed_q;
      lsb_d       = lsb_q;
      wdata_d     = wdata_q;
      ram_we_d    = ram_we_q;
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;
      rsp_valid_d = rsp_valid_q;
      rsp_err_d   = rsp_err_q;
      rsp_rdata_d = rsp_rdata_q;
      case (state_q)
         IDLE: begin
            if (Req_Valid) begin
               write_d  = Req_Write;
               size_d   = Req_Size;
               signed_d = Req_Signed;
               lsb_d    = Req_Addr[1:0];
               wdata_d  = Req_WData;
               if (misaligned(Req_Size, Req_Addr[1:0])) begin
                  state_d     = RESP;
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
                  rsp_rdata_d = '0;
               end
`ifdef MEM_WORD_FASTPATH_EN
               else if (Req_Write && (Req_Size == SIZE_W)) begin
                  state_d     = WR;
                  ram_we_d    = 1'b1;
                  ram_addr_d  = Req_Addr[ADDR_W-1:2];
                  ram_wdata_d = Req_WData;
               end
`endif
               else begin
                  state_d    = RD;
                  ram_addr_d = Req_Addr[ADDR_W-1:2];
               end
            end
         end
         RD: state_d = WAIT;
         WAIT: begin
            if (write_q) begin
               state_d     = WR;
               ram_we_d    = 1'b1;
               ram_wdata_d = merged_data;
            end else begin
               state_d     = RESP;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = load_data;
            end
         end
         WR: begin
            state_d     = RESP;
            ram_we_d    = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = '0;
         end
         RESP: begin
            state_d     = IDLE;
            rsp_valid_d = 1'b0;
            rsp_err_d   = 1'b0;
            rsp_rdata_d = '0;
         end
         default: state_d = IDLE;
      endcase
   end

   assign Req_Ready = (state_q == IDLE);
   assign Rsp_Valid = rsp_valid_q;
   assign Rsp_Err   = rsp_err_q;
   assign Rsp_RData = rsp_rdata_q;
   assign Ram_We    = ram_we_q;
   assign Ram_Addr  = ram_addr_q;
   assign Ram_WData = ram_wdata_q;

endmodule

// File: tb/tb_mem_byte_ctrl.sv
// Scoreboard bench for mem_byte_ctrl with a registered-read 64x32 RAM model.
// Honours MEM_WORD_FASTPATH_EN for the expected word-store latency.
module tb_mem_byte_ctrl;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;
   localparam logic [1:0] SZ_X = 2'b11;
`ifdef MEM_WORD_FASTPATH_EN
   localparam int WST_LAT = 2;
`else
   localparam int WST_LAT = 4;
`endif

   logic        Clk = 1'b0;
   logic        Rst_n = 1'b1;
   logic        Req_Valid = 1'b0;
   logic        Req_Ready;
   logic        Req_Write = 1'b0;
   logic [1:0]  Req_Size = 2'b00;
   logic        Req_Signed = 1'b0;
   logic [7:0]  Req_Addr = 8'h00;
   logic [31:0] Req_WData = 32'h0;
   logic        Rsp_Valid;
   logic [31:0] Rsp_RData;
   logic        Rsp_Err;
   logic        Ram_We;
   logic [5:0]  Ram_Addr;
   logic [31:0] Ram_WData;
   logic [31:0] Ram_RData = 32'h0;

   logic [31:0] mem [64];

   typedef struct {
      string       name;
      logic [31:0] data;
      logic        err;
      int          lat;
      int          acc;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   we_cnt = 0;

   mem_byte_ctrl #(.ADDR_W(8), .DATA_W(32)) dut (
      .Clk        (Clk),
      .Rst_n      (Rst_n),
      .Req_Valid  (Req_Valid),
      .Req_Ready  (Req_Ready),
      .Req_Write  (Req_Write),
      .Req_Size   (Req_Size),
      .Req_Signed (Req_Signed),
      .Req_Addr   (Req_Addr),
      .Req_WData  (Req_WData),
      .Rsp_Valid  (Rsp_Valid),
      .Rsp_RData  (Rsp_RData),
      .Rsp_Err    (Rsp_Err),
      .Ram_We     (Ram_We),
      .Ram_Addr   (Ram_Addr),
      .Ram_WData  (Ram_WData),
      .Ram_RData  (Ram_RData)
   );

   always #5 Clk = ~Clk;

   always @(posedge Clk) cyc <= cyc + 1;

   always @(posedge Clk) begin
      if (Ram_We) mem[Ram_Addr] <= Ram_WData;
      Ram_RData <= mem[Ram_Addr];
   end

   always @(negedge Clk) if (Ram_We) we_cnt <= we_cnt + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, expv);
      end
   endtask

   // Monitor: pops one expectation per response pulse.
   always @(negedge Clk) begin
      if (Rsp_Valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL rsp_unexpected: got data=%h err=%b expected no response", Rsp_RData, Rsp_Err);
         end else begin
            exp_t e;
            int   lat;
            e   = exp_q.pop_front();
            lat = cyc - e.acc + 1;
            $display("rsp %s data=%h err=%b lat=%0d", e.name, Rsp_RData, Rsp_Err, lat);
            chk({e.name, "_data"}, Rsp_RData, e.data);
            chk({e.name, "_err"}, {31'h0, Rsp_Err}, {31'h0, e.err});
            chk({e.name, "_lat"}, lat, e.lat);
         end
      end
   end

   task automatic push_exp(input string nm, input logic [31:0] ed, input logic ee, input int el);
      exp_t e;
      e.name = nm;
      e.data = ed;
      e.err  = ee;
      e.lat  = el;
      e.acc  = cyc;
      exp_q.push_back(e);
   endtask

   task automatic drain(input string nm);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 20) begin
         @(negedge Clk);
         n++;
      end
      chk({nm, "_drain"}, exp_q.size(), 0);
      exp_q.delete();
   endtask

   task automatic issue(input string nm, input logic w, input logic [1:0] sz, input logic sg,
                        input logic [7:0] a, input logic [31:0] wd,
                        input logic [31:0] ed, input logic ee, input int el);
      int n;
      @(negedge Clk);
      Req_Valid  = 1'b1;
      Req_Write  = w;
      Req_Size   = sz;
      Req_Signed = sg;
      Req_Addr   = a;
      Req_WData  = wd;
      n = 0;
      while (Req_Ready !== 1'b1 && n < 50) begin
         @(negedge Clk);
         n++;
      end
      if (Req_Ready !== 1'b1) begin
         chk({nm, "_ready"}, {31'h0, Req_Ready}, 32'h1);
         Req_Valid = 1'b0;
         return;
      end
      @(posedge Clk);
      #1;
      push_exp(nm, ed, ee, el);
      Req_Valid = 1'b0;
      drain(nm);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int we_before;
      for (int i = 0; i < 64; i++) mem[i] = 32'h0;
      mem[2] = 32'h5555_8888;

      #2 Rst_n = 1'b0;
      #1;
      chk("rst_ready", {31'h0, Req_Ready}, 32'h1);
      chk("rst_rsp_valid", {31'h0, Rsp_Valid}, 32'h0);
      chk("rst_rsp_err", {31'h0, Rsp_Err}, 32'h0);
      chk("rst_rsp_rdata", Rsp_RData, 32'h0);
      chk("rst_ram_we", {31'h0, Ram_We}, 32'h0);
      chk("rst_ram_addr", {26'h0, Ram_Addr}, 32'h0);
      chk("rst_ram_wdata", Ram_WData, 32'h0);
      repeat (3) @(negedge Clk);
      Rst_n = 1'b1;

      // T1
      issue("t1_st_w", 1'b1, SZ_W, 1'b0, 8'h04, 32'h3333_6666, 32'h0, 1'b0, WST_LAT);
      chk("t1_mem1", mem[1], 32'h3333_6666);
      issue("t1_ld_w", 1'b0, SZ_W, 1'b0, 8'h04, 32'h0, 32'h3333_6666, 1'b0, 3);

      // T2
      issue("t2_st_b", 1'b1, SZ_B, 1'b0, 8'h05, 32'h0000_00AB, 32'h0, 1'b0, 4);
      chk("t2_mem1", mem[1], 32'h3333_AB66);
      issue("t2_ld_bs", 1'b0, SZ_B, 1'b1, 8'h05, 32'h0, 32'hFFFF_FFAB, 1'b0, 3);
      issue("t2_ld_bu", 1'b0, SZ_B, 1'b0, 8'h05, 32'h0, 32'h0000_00AB, 1'b0, 3);

      // T3
      issue("t3_ld_hs8", 1'b0, SZ_H, 1'b1, 8'h08, 32'h0, 32'hFFFF_8888, 1'b0, 3);
      issue("t3_ld_hsA", 1'b0, SZ_H, 1'b1, 8'h0A, 32'h0, 32'h0000_5555, 1'b0, 3);
      issue("t3_st_h", 1'b1, SZ_H, 1'b0, 8'h0A, 32'hFFFF_1234, 32'h0, 1'b0, 4);
      chk("t3_mem2", mem[2], 32'h1234_8888);
      issue("t3_ld_w_sg", 1'b0, SZ_W, 1'b1, 8'h08, 32'h0, 32'h1234_8888, 1'b0, 3);

      // Top-of-memory byte lane
      issue("top_st_b", 1'b1, SZ_B, 1'b0, 8'hFF, 32'h0000_0080, 32'h0, 1'b0, 4);
      chk("top_mem63", mem[63], 32'h8000_0000);
      issue("top_ld_bs", 1'b0, SZ_B, 1'b1, 8'hFF, 32'h0, 32'hFFFF_FF80, 1'b0, 3);
      issue("top_ld_hu", 1'b0, SZ_H, 1'b0, 8'hFE, 32'h0, 32'h0000_8000, 1'b0, 3);

      // T4
      we_before = we_cnt;
      issue("t4_h_odd", 1'b0, SZ_H, 1'b0, 8'h03, 32'h0, 32'h0, 1'b1, 1);
      issue("t4_w_mis", 1'b1, SZ_W, 1'b0, 8'h06, 32'hDEAD_BEEF, 32'h0, 1'b1, 1);
      issue("t4_sz_x", 1'b1, SZ_X, 1'b0, 8'h00, 32'hCAFE_F00D, 32'h0, 1'b1, 1);
      chk("t4_no_we", we_cnt, we_before);
      chk("t4_mem0", mem[0], 32'h0);
      chk("t4_mem1", mem[1], 32'h3333_AB66);

      // T6: Valid held high across two loads
      @(negedge Clk);
      Req_Valid = 1'b1; Req_Write = 1'b0; Req_Size = SZ_W; Req_Signed = 1'b0; Req_Addr = 8'h04;
      chk("t6_ready_a", {31'h0, Req_Ready}, 32'h1);
      @(posedge Clk);
      #1;
      push_exp("t6_ld_a", 32'h3333_AB66, 1'b0, 3);
      Req_Size = SZ_B; Req_Signed = 1'b1; Req_Addr = 8'h08;
      for (int k = 0; k < 3; k++) begin
         @(negedge Clk);
         chk($sformatf("t6_busy%0d", k), {31'h0, Req_Ready}, 32'h0);
      end
      @(negedge Clk);
      chk("t6_ready_b", {31'h0, Req_Ready}, 32'h1);
      @(posedge Clk);
      #1;
      push_exp("t6_ld_b", 32'hFFFF_FF88, 1'b0, 3);
      Req_Valid = 1'b0;
      drain("t6");

      // T5: reset during the write cycle of a byte store
      @(negedge Clk);
      Req_Valid = 1'b1; Req_Write = 1'b1; Req_Size = SZ_B; Req_Signed = 1'b0;
      Req_Addr = 8'h0C; Req_WData = 32'h0000_00FF;
      @(posedge Clk);
      #1;
      Req_Valid = 1'b0;
      n = 0;
      while (Ram_We !== 1'b1 && n < 20) begin
         @(negedge Clk);
         n++;
      end
      chk("t5_we_seen", {31'h0, Ram_We}, 32'h1);
      #2 Rst_n = 1'b0;
      #1;
      chk("t5_we_drop", {31'h0, Ram_We}, 32'h0);
      chk("t5_rsp_valid", {31'h0, Rsp_Valid}, 32'h0);
      chk("t5_ready", {31'h0, Req_Ready}, 32'h1);
      chk("t5_ram_wdata", Ram_WData, 32'h0);
      @(posedge Clk);
      #1;
      chk("t5_mem3", mem[3], 32'h0);
      @(negedge Clk);
      Rst_n = 1'b1;
      @(negedge Clk);
      chk("t5_ready_rel", {31'h0, Req_Ready}, 32'h1);
      issue("t5_ld_after", 1'b0, SZ_W, 1'b0, 8'h0C, 32'h0, 32'h0, 1'b0, 3);
      issue("t5_ld_w8", 1'b0, SZ_W, 1'b0, 8'h08, 32'h0, 32'h1234_8888, 1'b0, 3);

      repeat (3) @(negedge Clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
